// File: rtl/uart_echo_fifo_if.sv
// Serial pins and status bundle of uart_echo_fifo.
// The slave modport is the echo block's view; master is the board or bench side.
interface uart_echo_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                        uart_rx;
    logic                        uart_tx;
    logic                        tx_hold;
    logic                        clr_overflow;
    logic                        rx_valid;
    logic [DATA_BITS-1:0]        rx_data;
    logic                        parity_err;
    logic                        frame_err;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        tx_busy;

    modport slave (
        input  uart_rx, tx_hold, clr_overflow,
        output uart_tx, rx_valid, rx_data, parity_err, frame_err, overflow, fifo_count, tx_busy
    );

    modport master (
        output uart_rx, tx_hold, clr_overflow,
        input  uart_tx, rx_valid, rx_data, parity_err, frame_err, overflow, fifo_count, tx_busy
    );
endinterface

// File: rtl/uart_echo_fifo.sv
// UART receiver and transmitter joined by a FIFO: every error-free received
// character is queued and echoed back in order.
module uart_echo_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic            sys_clk,
    input  logic            rst_n,
    uart_echo_fifo_if.slave bus
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int AW      = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(BPS_CNT / 2);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [AW:0]      FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~(^d) : (^d);
    endfunction

    logic                 rx_meta, rx_sync, rx_sync_d;
    logic [2:0]           rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [2:0]           rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_par;
    logic                 rx_valid_r, parity_err_r, frame_err_r;
    logic [DATA_BITS-1:0] rx_data_r;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 overflow_r;
    logic                 push_ok, full, pop, wr_en;

    logic [2:0]           tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [2:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par, tx_line, tx_busy_r;
    logic                 tx_bit_end, tx_ready;

    // RX leaves STOP at the mid-bit sample so a following start edge is never missed.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            rx_sync_d    <= 1'b1;
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_par       <= 1'b0;
            rx_valid_r   <= 1'b0;
            rx_data_r    <= '0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            rx_meta    <= bus.uart_rx;
            rx_sync    <= rx_meta;
            rx_sync_d  <= rx_sync;
            rx_valid_r <= 1'b0;
            if (rx_state != S_IDLE)
                rx_cnt <= (rx_cnt == CNT_LAST) ? '0 : rx_cnt + CNT_W'(1);
            case (rx_state)
                S_IDLE: begin
                    if (rx_sync_d && !rx_sync) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (rx_cnt == CNT_MID && rx_sync) begin
                        rx_state <= S_IDLE;
                    end else if (rx_cnt == CNT_LAST) begin
                        rx_state <= S_DATA;
                        rx_bit   <= '0;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == CNT_MID)
                        rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_cnt == CNT_LAST) begin
                        if (rx_bit == BIT_LAST)
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (rx_cnt == CNT_MID)
                        rx_par <= rx_sync;
                    if (rx_cnt == CNT_LAST)
                        rx_state <= S_STOP;
                end
                S_STOP: begin
                    if (rx_cnt == CNT_MID) begin
                        rx_state     <= S_IDLE;
                        rx_valid_r   <= 1'b1;
                        rx_data_r    <= rx_shift;
                        parity_err_r <= (PARITY != 0) && (rx_par != parity_bit(rx_shift));
                        frame_err_r  <= !rx_sync;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok = rx_valid_r && !parity_err_r && !frame_err_r;
    assign full    = (count == FULL_CNT);
    assign pop     = tx_ready && (count != '0) && !bus.tx_hold;
    assign wr_en   = push_ok && (!full || pop);

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_ptr] <= rx_data_r;
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)
                count <= count + (AW + 1)'(1);
            else if (!wr_en && pop)
                count <= count - (AW + 1)'(1);
            if (push_ok && full && !pop)
                overflow_r <= 1'b1;
            else if (bus.clr_overflow)
                overflow_r <= 1'b0;
        end
    end

    // TX may pop in the last stop-bit cycle, so queued frames go out with no idle gap.
    assign tx_bit_end = (tx_cnt == CNT_LAST);
    assign tx_ready   = (tx_state == S_IDLE) ||
                        (tx_state == S_STOP && tx_bit_end && tx_bit == STOP_LAST);

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            tx_state  <= S_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_line   <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            if (tx_state != S_IDLE)
                tx_cnt <= tx_bit_end ? '0 : tx_cnt + CNT_W'(1);
            if (pop) begin
                tx_state  <= S_START;
                tx_cnt    <= '0;
                tx_shift  <= mem[rd_ptr];
                tx_par    <= parity_bit(mem[rd_ptr]);
                tx_line   <= 1'b0;
                tx_busy_r <= 1'b1;
            end else begin
                case (tx_state)
                    S_START: begin
                        if (tx_bit_end) begin
                            tx_state <= S_DATA;
                            tx_bit   <= '0;
                            tx_line  <= tx_shift[0];
                        end
                    end
                    S_DATA: begin
                        if (tx_bit_end) begin
                            if (tx_bit == BIT_LAST) begin
                                tx_bit <= '0;
                                if (PARITY != 0) begin
                                    tx_state <= S_PARITY;
                                    tx_line  <= tx_par;
                                end else begin
                                    tx_state <= S_STOP;
                                    tx_line  <= 1'b1;
                                end
                            end else begin
                                tx_bit   <= tx_bit + 3'd1;
                                tx_shift <= tx_shift >> 1;
                                tx_line  <= tx_shift[1];
                            end
                        end
                    end
                    S_PARITY: begin
                        if (tx_bit_end) begin
                            tx_state <= S_STOP;
                            tx_line  <= 1'b1;
                        end
                    end
                    S_STOP: begin
                        if (tx_bit_end) begin
                            if (tx_bit == STOP_LAST) begin
                                tx_state  <= S_IDLE;
                                tx_busy_r <= 1'b0;
                            end else begin
                                tx_bit <= tx_bit + 3'd1;
                            end
                        end
                    end
                    default: tx_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.uart_tx    = tx_line;
    assign bus.tx_busy    = tx_busy_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.rx_data    = rx_data_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.overflow   = overflow_r;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_echo_fifo.sv
// Bench for uart_echo_fifo: instance A is 8N1 with a 4-deep FIFO, instance B is
// 8 bits, even parity, 2 TX stop bits; both run at 10 clocks per bit.
module tb_uart_echo_fifo;
    localparam int BPS = 10;

    typedef struct {
        logic [7:0]  data;
        logic [15:0] bits;
        int          start;
        bit          ok;
    } txrec_t;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } rxrec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] rx_line = 2'b11;
    logic [1:0] hold = 2'b00;
    logic [1:0] clr = 2'b00;
    logic [1:0] tx_mon;
    int         cyc = 0;
    int         last_reset_cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;
    txrec_t     txq_a[$];
    txrec_t     txq_b[$];
    rxrec_t     rxq_a[$];
    rxrec_t     rxq_b[$];
    rxrec_t     ra, rb;

    uart_echo_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  a_if ();
    uart_echo_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) b_if ();

    uart_echo_fifo #(
        .CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .sys_clk(clk), .rst_n(rst_n), .bus(a_if.slave)
    );

    uart_echo_fifo #(
        .CLK_FREQ(50_000_000), .UART_BPS(5_000_000), .DATA_BITS(8),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)
    ) dut_b (
        .sys_clk(clk), .rst_n(rst_n), .bus(b_if.slave)
    );

    assign a_if.uart_rx      = rx_line[0];
    assign b_if.uart_rx      = rx_line[1];
    assign a_if.tx_hold      = hold[0];
    assign b_if.tx_hold      = hold[1];
    assign a_if.clr_overflow = clr[0];
    assign b_if.clr_overflow = clr[1];
    assign tx_mon            = {b_if.uart_tx, a_if.uart_tx};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n)
            last_reset_cyc <= cyc;
    end

    always @(negedge clk) begin
        if (a_if.rx_valid === 1'b1) begin
            ra.data = a_if.rx_data; ra.perr = a_if.parity_err; ra.ferr = a_if.frame_err; ra.cyc = cyc;
            rxq_a.push_back(ra);
        end
        if (b_if.rx_valid === 1'b1) begin
            rb.data = b_if.rx_data; rb.perr = b_if.parity_err; rb.ferr = b_if.frame_err; rb.cyc = cyc;
            rxq_b.push_back(rb);
        end
    end

    // Reference serial frame: start 0, data LSB first, optional parity, stop bits.
    function automatic logic [15:0] build_frame(input logic [7:0] d, input int mode, input int stops);
        logic [15:0] f;
        int k;
        f = '0;
        k = 1;
        for (int i = 0; i < 8; i++) begin
            f[k] = d[i];
            k++;
        end
        if (mode == 1) begin
            f[k] = ~(^d);
            k++;
        end else if (mode == 2) begin
            f[k] = ^d;
            k++;
        end
        for (int i = 0; i < stops; i++) begin
            f[k] = 1'b1;
            k++;
        end
        return f;
    endfunction

    // Captures each TX frame cycle by cycle; frames cut short by reset are discarded.
    task automatic tx_monitor(input int id, input int n);
        txrec_t r;
        logic   v;
        logic   prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            v = tx_mon[id];
            if (rst_n === 1'b1 && prev === 1'b1 && v === 1'b0) begin
                r.start = cyc;
                r.bits  = '0;
                r.ok    = 1'b1;
                for (int t = 0; t < n * BPS; t++) begin
                    if (t > 0) begin
                        @(negedge clk);
                        v = tx_mon[id];
                    end
                    if (t % BPS == 0)
                        r.bits[t / BPS] = v;
                    else if (v !== r.bits[t / BPS])
                        r.ok = 1'b0;
                end
                r.data = r.bits[8:1];
                if (last_reset_cyc < r.start) begin
                    if (id == 0) txq_a.push_back(r);
                    else         txq_b.push_back(r);
                end
            end
            prev = v;
        end
    endtask

    initial tx_monitor(0, 10);
    initial tx_monitor(1, 12);

    task automatic send_frame(input int id, input logic [7:0] d, input int mode, input bit bad_par, input bit stop_val);
        logic [15:0] f;
        int n;
        n = (mode != 0) ? 11 : 10;
        f = build_frame(d, mode, 1);
        if (mode != 0 && bad_par)
            f[9] = ~f[9];
        f[n-1] = stop_val;
        for (int i = 0; i < n; i++) begin
            rx_line[id] = f[i];
            repeat (BPS) @(negedge clk);
        end
        rx_line[id] = 1'b1;
    endtask

    task automatic wait_q(input int id, input int n, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if ((id == 0 && txq_a.size() >= n) || (id == 1 && txq_b.size() >= n))
                break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (a_if.uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset uart_tx: got %b want 1", a_if.uart_tx); end
        tests_run++; if (a_if.tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset tx_busy: got %b want 0", a_if.tx_busy); end
        tests_run++; if (a_if.rx_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset rx_valid: got %b want 0", a_if.rx_valid); end
        tests_run++; if (a_if.rx_data !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset rx_data: got %h want 00", a_if.rx_data); end
        tests_run++; if ({a_if.parity_err, a_if.frame_err} !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset errors: got %b want 00", {a_if.parity_err, a_if.frame_err}); end
        tests_run++; if (a_if.overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset overflow: got %b want 0", a_if.overflow); end
        tests_run++; if (a_if.fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset fifo_count: got %0d want 0", a_if.fifo_count); end
        tests_run++; if (b_if.uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset b uart_tx: got %b want 1", b_if.uart_tx); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_echo();
        rxq_a.delete();
        txq_a.delete();
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1);
        wait_q(0, 1, 300);
        tests_run++;
        if (rxq_a.size() != 1 || rxq_a[0].data !== 8'hA5 || rxq_a[0].perr !== 1'b0 || rxq_a[0].ferr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL echo rx event: got %0d events first=%h, want 1 event A5 without errors", rxq_a.size(), rxq_a.size() > 0 ? rxq_a[0].data : 8'hxx);
        end
        tests_run++;
        if (txq_a.size() != 1 || txq_a[0].bits !== build_frame(8'hA5, 0, 1) || !txq_a[0].ok) begin
            tests_failed++;
            $display("[TB] FAIL echo frame: got %0d frames bits=%b, want 1 frame %b", txq_a.size(), txq_a.size() > 0 ? txq_a[0].bits : 16'hxxxx, build_frame(8'hA5, 0, 1));
        end
        if (txq_a.size() > 0 && rxq_a.size() > 0) begin
            tests_run++;
            if (txq_a[0].start - rxq_a[0].cyc != 2) begin
                tests_failed++;
                $display("[TB] FAIL echo latency: got %0d cycles want 2", txq_a[0].start - rxq_a[0].cyc);
            end
        end
    endtask

    task automatic test_random_echo();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        rxq_a.delete();
        txq_a.delete();
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(0, d, 0, 1'b0, 1'b1);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end
        wait_q(0, 6, 400);
        tests_run++;
        if (txq_a.size() != 6) begin tests_failed++; $display("[TB] FAIL random echo count: got %0d want 6", txq_a.size()); end
        for (int i = 0; i < exp_q.size() && i < txq_a.size(); i++) begin
            tests_run++;
            if (txq_a[i].bits !== build_frame(exp_q[i], 0, 1) || !txq_a[i].ok) begin
                tests_failed++;
                $display("[TB] FAIL random echo %0d: got %h want %h", i, txq_a[i].data, exp_q[i]);
            end
        end
    endtask

    task automatic test_parity();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        rxq_b.delete();
        txq_b.delete();
        send_frame(1, 8'h03, 2, 1'b1, 1'b1);
        repeat (20) @(negedge clk);
        tests_run++;
        if (rxq_b.size() != 1 || rxq_b[0].perr !== 1'b1 || rxq_b[0].ferr !== 1'b0 || rxq_b[0].data !== 8'h03) begin
            tests_failed++;
            $display("[TB] FAIL parity error flag: got %0d events perr=%b, want 1 event perr=1", rxq_b.size(), rxq_b.size() > 0 ? rxq_b[0].perr : 1'bx);
        end
        tests_run++; if (b_if.fifo_count !== 5'd0) begin tests_failed++; $display("[TB] FAIL parity no push: got count %0d want 0", b_if.fifo_count); end
        repeat (150) @(negedge clk);
        tests_run++; if (txq_b.size() != 0) begin tests_failed++; $display("[TB] FAIL parity no tx: got %0d frames want 0", txq_b.size()); end
        send_frame(1, 8'h03, 2, 1'b0, 1'b1);
        wait_q(1, 1, 300);
        tests_run++;
        if (txq_b.size() != 1 || txq_b[0].bits !== build_frame(8'h03, 2, 2) || !txq_b[0].ok) begin
            tests_failed++;
            $display("[TB] FAIL parity echo: got %0d frames bits=%b want %b", txq_b.size(), txq_b.size() > 0 ? txq_b[0].bits : 16'hxxxx, build_frame(8'h03, 2, 2));
        end
        txq_b.delete();
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(1, d, 2, 1'b0, 1'b1);
        end
        wait_q(1, 4, 600);
        tests_run++;
        if (txq_b.size() != 4) begin tests_failed++; $display("[TB] FAIL parity random count: got %0d want 4", txq_b.size()); end
        for (int i = 0; i < exp_q.size() && i < txq_b.size(); i++) begin
            tests_run++;
            if (txq_b[i].bits !== build_frame(exp_q[i], 2, 2) || !txq_b[i].ok) begin
                tests_failed++;
                $display("[TB] FAIL parity random %0d: got bits %b want %b", i, txq_b[i].bits, build_frame(exp_q[i], 2, 2));
            end
        end
    endtask

    task automatic test_framing();
        rxq_a.delete();
        txq_a.delete();
        send_frame(0, 8'h5A, 0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        tests_run++;
        if (rxq_a.size() != 1 || rxq_a[0].ferr !== 1'b1 || rxq_a[0].perr !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL frame error flag: got %0d events ferr=%b, want 1 event ferr=1", rxq_a.size(), rxq_a.size() > 0 ? rxq_a[0].ferr : 1'bx);
        end
        tests_run++; if (a_if.fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL frame no push: got count %0d want 0", a_if.fifo_count); end
        repeat (120) @(negedge clk);
        tests_run++; if (txq_a.size() != 0) begin tests_failed++; $display("[TB] FAIL frame no tx: got %0d frames want 0", txq_a.size()); end
    endtask

    task automatic test_glitch();
        rxq_a.delete();
        txq_a.delete();
        rx_line[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_line[0] = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++; if (rxq_a.size() != 0) begin tests_failed++; $display("[TB] FAIL glitch rx_valid: got %0d events want 0", rxq_a.size()); end
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
        wait_q(0, 1, 300);
        tests_run++;
        if (rxq_a.size() != 1 || rxq_a[0].data !== 8'h3C || txq_a.size() != 1 || txq_a[0].data !== 8'h3C) begin
            tests_failed++;
            $display("[TB] FAIL glitch recovery: got %0d rx %0d tx, want one 3C each", rxq_a.size(), txq_a.size());
        end
    endtask

    task automatic test_overflow();
        rxq_a.delete();
        txq_a.delete();
        hold[0] = 1'b1;
        for (int i = 0; i < 6; i++)
            send_frame(0, 8'(8'h10 + i), 0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        tests_run++; if (a_if.fifo_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL overflow count: got %0d want 4", a_if.fifo_count); end
        tests_run++; if (a_if.overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow flag: got %b want 1", a_if.overflow); end
        tests_run++; if (txq_a.size() != 0 || rxq_a.size() != 6) begin tests_failed++; $display("[TB] FAIL overflow hold: got %0d tx %0d rx, want 0 tx 6 rx", txq_a.size(), rxq_a.size()); end
        hold[0] = 1'b0;
        wait_q(0, 4, 600);
        repeat (200) @(negedge clk);
        tests_run++; if (txq_a.size() != 4) begin tests_failed++; $display("[TB] FAIL overflow drain count: got %0d want 4", txq_a.size()); end
        for (int i = 0; i < 4 && i < txq_a.size(); i++) begin
            tests_run++;
            if (txq_a[i].bits !== build_frame(8'(8'h10 + i), 0, 1) || !txq_a[i].ok) begin
                tests_failed++;
                $display("[TB] FAIL overflow drain %0d: got %h want %h", i, txq_a[i].data, 8'(8'h10 + i));
            end
            if (i > 0) begin
                tests_run++;
                if (txq_a[i].start - txq_a[i-1].start != 10 * BPS) begin
                    tests_failed++;
                    $display("[TB] FAIL overflow spacing %0d: got %0d cycles want %0d", i, txq_a[i].start - txq_a[i-1].start, 10 * BPS);
                end
            end
        end
        tests_run++; if (a_if.overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL overflow sticky: got %b want 1", a_if.overflow); end
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        tests_run++; if (a_if.overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL overflow clear: got %b want 0", a_if.overflow); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q[$];
        logic [7:0] d;
        rxq_a.delete();
        txq_a.delete();
        hold[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            send_frame(0, d, 0, 1'b0, 1'b1);
        end
        d = 8'($urandom_range(0, 255));
        exp_q.push_back(d);
        fork
            send_frame(0, d, 0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (a_if.rx_valid === 1'b1) begin
                        hold[0] = 1'b0;
                        break;
                    end
                end
            end
        join
        hold[0] = 1'b0;
        tests_run++; if (a_if.fifo_count !== 3'd4) begin tests_failed++; $display("[TB] FAIL full pop count: got %0d want 4", a_if.fifo_count); end
        tests_run++; if (a_if.overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL full pop overflow: got %b want 0", a_if.overflow); end
        wait_q(0, 5, 700);
        tests_run++; if (txq_a.size() != 5) begin tests_failed++; $display("[TB] FAIL full pop frames: got %0d want 5", txq_a.size()); end
        for (int i = 0; i < 5 && i < txq_a.size(); i++) begin
            tests_run++;
            if (txq_a[i].data !== exp_q[i] || !txq_a[i].ok) begin
                tests_failed++;
                $display("[TB] FAIL full pop data %0d: got %h want %h", i, txq_a[i].data, exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        txq_a.delete();
        hold[0] = 1'b1;
        for (int i = 0; i < 3; i++)
            send_frame(0, 8'(8'h61 + i), 0, 1'b0, 1'b1);
        hold[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (a_if.tx_busy === 1'b1) break;
            @(negedge clk);
        end
        repeat (35) @(negedge clk);
        tests_run++; if (a_if.fifo_count !== 3'd2 || a_if.tx_busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL midframe setup: got count %0d busy %b want 2 and 1", a_if.fifo_count, a_if.tx_busy); end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++; if (a_if.uart_tx !== 1'b1) begin tests_failed++; $display("[TB] FAIL midframe uart_tx: got %b want 1", a_if.uart_tx); end
        tests_run++; if (a_if.tx_busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL midframe tx_busy: got %b want 0", a_if.tx_busy); end
        tests_run++; if (a_if.fifo_count !== 3'd0) begin tests_failed++; $display("[TB] FAIL midframe fifo_count: got %0d want 0", a_if.fifo_count); end
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        tests_run++;
        if (txq_a.size() != 0 || a_if.uart_tx !== 1'b1 || a_if.fifo_count !== 3'd0) begin
            tests_failed++;
            $display("[TB] FAIL midframe after release: got %0d frames tx=%b count=%0d, want 0 1 0", txq_a.size(), a_if.uart_tx, a_if.fifo_count);
        end
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_echo();
        test_random_echo();
        test_parity();
        test_framing();
        test_glitch();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
